// File: rtl/cram_loader.sv
`default_nettype none
// ============================================================================
// cram_loader - serialises host words MSB-first into a CRAM config chain;
//               define CRAM_LOADER_CRC_EN for the CRC-8 trailer check.  Rev 1.0
// ============================================================================
module cram_loader #(
  parameter int WORD_W     = 8,
  parameter int CHAIN_BITS = 232,
  parameter int NUM_CELLS  = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_data,
  output logic              cfg_en,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int TOTAL     = CHAIN_BITS * NUM_CELLS;
  localparam int NWORDS    = (TOTAL + WORD_W - 1) / WORD_W;
  localparam int TAIL_BITS = TOTAL - (NWORDS - 1) * WORD_W;
  localparam int CNT_W     = $clog2(WORD_W + 1);
  localparam int BITS_W    = $clog2(TOTAL + 1);
  localparam int WORDS_W   = $clog2(NWORDS + 1);

`ifdef CRAM_LOADER_CRC_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_CHECK = 2'd2, S_FIN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_FIN = 2'd3} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_sr;
  logic [CNT_W-1:0]    r_sr_cnt;
  logic [BITS_W-1:0]   r_bits_left;
  logic [WORDS_W-1:0]  r_words_left;
  logic                r_cfg_data, r_cfg_en, r_busy, r_done;
  logic                w_ready, w_xfer, w_shift, w_last_bit, w_next_bit, w_in_load;
  logic [CNT_W-1:0]    w_word_bits;
  logic                w_unused_tail;

  assign w_unused_tail = chain_tail;

`ifdef CRAM_LOADER_CRC_EN
  assign w_in_load = (r_state == S_SHIFT) || (r_state == S_CHECK);
`else
  assign w_in_load = (r_state == S_SHIFT);
`endif

  assign w_ready     = w_in_load && en && (r_sr_cnt <= CNT_W'(1)) && (r_words_left != '0);
  assign w_xfer      = w_ready && word_valid;
  assign w_shift     = en && (r_state == S_SHIFT) && ((r_sr_cnt != '0) || w_xfer);
  // With sr_cnt==1 the old last bit goes out this edge, so a new word is loaded whole.
  assign w_next_bit  = (r_sr_cnt != '0) ? r_sr[WORD_W-1] : word_in[WORD_W-1];
  assign w_last_bit  = w_shift && (r_bits_left == BITS_W'(1));
  assign w_word_bits = (r_words_left == WORDS_W'(1)) ? CNT_W'(TAIL_BITS) : CNT_W'(WORD_W);

`ifdef CRAM_LOADER_CRC_EN
  logic [7:0] r_crc;
  logic [7:0] w_crc_rx;
  logic       r_err, w_crc_fb;
  assign w_crc_fb = r_crc[7] ^ w_next_bit;
  assign w_crc_rx = word_in[7:0];
  assign err      = r_err;
`else
  assign err      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (en) begin
      case (r_state)
        S_IDLE:  if (start) w_state_nxt = S_SHIFT;
`ifdef CRAM_LOADER_CRC_EN
        S_SHIFT: if (w_last_bit) w_state_nxt = S_CHECK;
        S_CHECK: if (w_xfer) w_state_nxt = S_FIN;
`else
        S_SHIFT: if (w_last_bit) w_state_nxt = S_FIN;
`endif
        S_FIN:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sr         <= '0;
      r_sr_cnt     <= '0;
      r_bits_left  <= '0;
      r_words_left <= '0;
      r_cfg_data   <= 1'b0;
      r_cfg_en     <= 1'b0;
      r_done       <= 1'b0;
`ifdef CRAM_LOADER_CRC_EN
      r_crc        <= '0;
      r_err        <= 1'b0;
`endif
    end else if (!en) begin
      r_cfg_en <= 1'b0;
    end else begin
      r_cfg_en <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        r_sr_cnt     <= '0;
        r_bits_left  <= BITS_W'(TOTAL);
        r_words_left <= WORDS_W'(NWORDS);
        r_done       <= 1'b0;
`ifdef CRAM_LOADER_CRC_EN
        r_crc        <= '0;
        r_err        <= 1'b0;
`endif
      end
      if (w_shift) begin
        r_cfg_data  <= w_next_bit;
        r_cfg_en    <= 1'b1;
        r_bits_left <= r_bits_left - BITS_W'(1);
`ifdef CRAM_LOADER_CRC_EN
        r_crc       <= {r_crc[6:0], 1'b0} ^ (w_crc_fb ? 8'h07 : 8'h00);
`endif
      end
      if (w_xfer && (r_state == S_SHIFT)) begin
        r_words_left <= r_words_left - WORDS_W'(1);
        if (r_sr_cnt == '0) begin
          r_sr     <= word_in << 1;
          r_sr_cnt <= w_word_bits - CNT_W'(1);
        end else begin
          r_sr     <= word_in;
          r_sr_cnt <= w_word_bits;
        end
      end else if (w_shift) begin
        r_sr     <= r_sr << 1;
        r_sr_cnt <= r_sr_cnt - CNT_W'(1);
      end
`ifdef CRAM_LOADER_CRC_EN
      // Re-arm the word counter so the normal ready rule admits the one CRC word.
      if (w_last_bit) r_words_left <= WORDS_W'(1);
      if (w_xfer && (r_state == S_CHECK)) begin
        r_words_left <= '0;
        if (w_crc_rx != r_crc) r_err <= 1'b1;
      end
`endif
      if (r_state == S_FIN) r_done <= 1'b1;
    end
  end

  assign word_ready = w_ready;
  assign cfg_data   = r_cfg_data;
  assign cfg_en     = r_cfg_en;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire
